mx_pe_stream_ctrl: RTL

//  Streaming controller in front of Block_PE_wrapper. Buffers A/B MX operand blocks with shared exponents and issues them as joint pairs.

---
 rtl/mx_pe_pkg.sv | 40 ++++
 rtl/mx_stream_fifo.sv | 58 +++++
 rtl/mx_pe_stream_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mx_pe_pkg.sv
// Shared types and constants for the MX PE streaming controller.
//   prec_e       : precision mode encoding driven to the PE
//   fp_e         : FP sub-format selector driven to the PE
//   ctrl_state_e : controller FSM states
//   MX_EXP_NAN   : E8M0 shared-scale value that encodes NaN
//   mx_operand_t : one operand FIFO entry {data, exp} at the default widths
package mx_pe_pkg;

  localparam int MX_DATA_W = 256;
  localparam int MX_EXP_W  = 8;

  typedef enum logic [1:0] {
    PREC_INT8 = 2'b00,
    PREC_FP8  = 2'b01,
    PREC_FP4  = 2'b11
  } prec_e;

  typedef enum logic [1:0] {
    FP_MODE_0 = 2'b00,
    FP_MODE_1 = 2'b01,
    FP_MODE_2 = 2'b10,
    FP_MODE_3 = 2'b11
  } fp_e;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT,
    CLEAR
  } ctrl_state_e;

  localparam logic [7:0] MX_EXP_NAN = 8'hFF;

  typedef struct packed {
    logic [MX_DATA_W-1:0] data;
    logic [MX_EXP_W-1:0]  exp;
  } mx_operand_t;

endpackage

// File: rtl/mx_stream_fifo.sv
// Small synchronous FIFO for one operand stream.
//   clk_i, rst_i     : clock, synchronous active-high reset (flushes)
//   push_i, data_i   : write strobe and entry (ignored while full)
//   pop_i            : remove head entry (ignored while empty)
//   full_o, empty_o  : occupancy flags
//   head_o           : oldest entry, visible the cycle after it is written
module mx_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  import mx_pe_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mx_pe_stream_ctrl.sv
// Streaming controller in front of the MX block PE. Buffers A/B operand
// blocks, issues exactly k_len joint pairs, waits out the PE latency, strobes
// the PE capture, holds the result on a valid/ready port and clears the PE
// accumulator.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   cfg_*                       : job configuration handshake (accepted in IDLE)
//   a_*, b_*                    : operand streams (valid/ready, data, shared exp)
//   pe_*_o                      : PE operand issue, modes, capture and clear strobes
//   pe_out_i, pe_exp_out_i      : requantised PE result
//   res_*                       : result port (valid/ready, data, exp, NaN flag)
// Build option: MX_NAN_FLAG_EN adds a sticky NaN-scale flag reported on
// res_nan_o; without it res_nan_o is tied low.
//
// state  | meaning
// IDLE   | waiting for cfg handshake, operands may queue, nothing issued
// ACCUM  | issuing pairs while both FIFO heads are valid, until k_len issued
// DRAIN  | waiting PE_LAT cycles for the accumulator to settle
// OUTPUT | capture the PE result once the result buffer is free
// CLEAR  | one-cycle accumulator clear
module mx_pe_stream_ctrl #(
  parameter int DATA_W     = 256,
  parameter int EXP_W      = 8,
  parameter int OUT_W      = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int K_W        = 8,
  parameter int PE_LAT     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [1:0]        cfg_prec_i,
  input  logic [1:0]        cfg_fp_i,
  input  logic [K_W-1:0]    cfg_k_len_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [EXP_W-1:0]  a_exp_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic [EXP_W-1:0]  b_exp_i,
  output logic              pe_a_valid_o,
  output logic              pe_b_valid_o,
  output logic [DATA_W-1:0] pe_a_data_o,
  output logic [DATA_W-1:0] pe_b_data_o,
  output logic [EXP_W-1:0]  pe_a_exp_o,
  output logic [EXP_W-1:0]  pe_b_exp_o,
  output logic [1:0]        pe_prec_o,
  output logic [1:0]        pe_fp_o,
  output logic [1:0]        pe_prec_quan_o,
  output logic [1:0]        pe_fp_quan_o,
  output logic              pe_send_output_o,
  output logic              pe_acc_clr_o,
  input  logic [OUT_W-1:0]  pe_out_i,
  input  logic [EXP_W-1:0]  pe_exp_out_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [OUT_W-1:0]  res_data_o,
  output logic [EXP_W-1:0]  res_exp_o,
  output logic              res_nan_o
);
  import mx_pe_pkg::*;

  // PE_LAT is expected to be at least 1.
  localparam int LAT_W = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;
  localparam int OP_W  = DATA_W + EXP_W;

  ctrl_state_e      state;
  logic [K_W-1:0]   k_cnt;
  logic [K_W-1:0]   k_len_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             clr_pend;
  logic             a_full, a_empty, b_full, b_empty;
  logic [OP_W-1:0]  a_head, b_head;
  logic             issue;
  logic             capture;

  assign a_ready_o = ~a_full;
  assign b_ready_o = ~b_full;

  mx_stream_fifo #(.W(OP_W), .DEPTH(FIFO_DEPTH)) u_a_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (a_valid_i & a_ready_o),
    .data_i  ({a_data_i, a_exp_i}),
    .pop_i   (issue),
    .full_o  (a_full),
    .empty_o (a_empty),
    .head_o  (a_head)
  );

  mx_stream_fifo #(.W(OP_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (b_valid_i & b_ready_o),
    .data_i  ({b_data_i, b_exp_i}),
    .pop_i   (issue),
    .full_o  (b_full),
    .empty_o (b_empty),
    .head_o  (b_head)
  );

  assign issue   = (state == ACCUM) & ~a_empty & ~b_empty;
  assign capture = (state == OUTPUT) & (~res_valid_o | res_ready_i);

  // Operand buses are zeroed when not issuing so the PE never sees stale FIFO contents.
  assign pe_a_valid_o = issue;
  assign pe_b_valid_o = issue;
  assign pe_a_data_o  = issue ? a_head[OP_W-1:EXP_W] : '0;
  assign pe_a_exp_o   = issue ? a_head[EXP_W-1:0]    : '0;
  assign pe_b_data_o  = issue ? b_head[OP_W-1:EXP_W] : '0;
  assign pe_b_exp_o   = issue ? b_head[EXP_W-1:0]    : '0;

  assign cfg_ready_o      = (state == IDLE);
  assign pe_send_output_o = capture;
  // After any reset the PE accumulator may hold a partial sum, so clear it once.
  assign pe_acc_clr_o     = (state == CLEAR) | (clr_pend & ~rst_i);
  assign pe_prec_quan_o   = pe_prec_o;
  assign pe_fp_quan_o     = pe_fp_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      k_cnt       <= '0;
      k_len_q     <= '0;
      lat_cnt     <= '0;
      clr_pend    <= 1'b1;
      pe_prec_o   <= '0;
      pe_fp_o     <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_exp_o   <= '0;
    end else begin
      clr_pend <= 1'b0;
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            pe_prec_o <= cfg_prec_i;
            pe_fp_o   <= cfg_fp_i;
            k_len_q   <= (cfg_k_len_i == '0) ? K_W'(1) : cfg_k_len_i;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (issue) begin
            k_cnt <= k_cnt + K_W'(1);
            if (k_cnt + K_W'(1) == k_len_q) begin
              lat_cnt <= '0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (lat_cnt == LAT_W'(PE_LAT - 1)) state <= OUTPUT;
          else lat_cnt <= lat_cnt + LAT_W'(1);
        end
        OUTPUT: begin
          if (capture) begin
            res_data_o  <= pe_out_i;
            res_exp_o   <= pe_exp_out_i;
            res_valid_o <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          k_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MX_NAN_FLAG_EN
  logic nan_flag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nan_flag  <= 1'b0;
      res_nan_o <= 1'b0;
    end else begin
      if (state == CLEAR) nan_flag <= 1'b0;
      else if (issue && ((a_head[EXP_W-1:0] == EXP_W'(MX_EXP_NAN)) ||
                         (b_head[EXP_W-1:0] == EXP_W'(MX_EXP_NAN))))
        nan_flag <= 1'b1;
      if (capture) res_nan_o <= nan_flag;
    end
  end
`else
  assign res_nan_o = 1'b0;
`endif

endmodule
